// File: rtl/fetch_queue_nw.sv
// ----------------------------------------------------------------------------
// fetch_queue_nw
//   N-wide instruction fetch stage feeding a DEPTH-entry circular queue.
//   Each cycle with enough free space, FETCH_WIDTH consecutive words are read
//   from instruction memory and pushed together with their PCs. Decode pops
//   up to FETCH_WIDTH of the oldest entries per cycle. A redirect from
//   execute flushes the queue and restarts fetch at the new PC.
//
// Optional feature macro: FETCHQ_PERF_EN
//   When defined, adds saturating performance counters
//   perf_full_cycles_o (fetch stalled on a full queue) and
//   perf_redirects_o (redirect cycles). Core behaviour is unchanged.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active high
//   redirect_i     in   flush queue and restart fetch at redirect_pc_i
//   redirect_pc_i  in   new fetch PC (bits [1:0] forced to zero)
//   imem_addr_o    out  fetch base address (current fetch PC)
//   imem_rdata_i   in   slot k = mem[imem_addr_o + 4k], combinational read
//   deq_count_i    in   entries consumed by decode this cycle
//   instr_o        out  slot k = k-th oldest queued instruction
//   pc_o           out  PC of instr_o slot k
//   valid_o        out  slot k valid iff count_o > k (prefix-contiguous)
//   count_o        out  occupied entries
// ----------------------------------------------------------------------------
module fetch_queue_nw #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          DEPTH       = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               redirect_i,
    input  logic [31:0]                        redirect_pc_i,
    output logic [31:0]                        imem_addr_o,
    input  logic [32*FETCH_WIDTH-1:0]          imem_rdata_i,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]   deq_count_i,
    output logic [32*FETCH_WIDTH-1:0]          instr_o,
    output logic [32*FETCH_WIDTH-1:0]          pc_o,
    output logic [FETCH_WIDTH-1:0]             valid_o,
    output logic [$clog2(DEPTH+1)-1:0]         count_o
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]                        perf_full_cycles_o,
    output logic [31:0]                        perf_redirects_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc_q;

    logic          w_fetch_go;
    logic [CW-1:0] w_pop_n;
    logic [CW-1:0] w_push_n;

    // Push/pop decisions. Fetch looks only at the current occupancy (no credit
    // for entries popped this cycle) so a push never overwrites a live entry.
    always_comb begin
        w_fetch_go = (redirect_i == 1'b0) && (r_count <= CW'(DEPTH - FETCH_WIDTH));
        if (CW'(deq_count_i) > r_count) begin
            w_pop_n = r_count;
        end else begin
            w_pop_n = CW'(deq_count_i);
        end
        if (w_fetch_go) begin
            w_push_n = CW'(FETCH_WIDTH);
        end else begin
            w_push_n = {CW{1'b0}};
        end
    end

    // Queue storage, pointers, occupancy and fetch PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q  <= RESET_PC;
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= 32'h0000_0000;
                r_mem_pc[i]    <= 32'h0000_0000;
            end
        end else if (redirect_i) begin
            // Flush: pending pops and the fetch of this cycle are discarded.
            r_pc_q  <= {redirect_pc_i[31:2], 2'b00};
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_fetch_go) begin
                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    r_mem_instr[r_tail + PW'(k)] <= imem_rdata_i[32*k +: 32];
                    r_mem_pc[r_tail + PW'(k)]    <= r_pc_q + 32'(4*k);
                end
                r_tail <= r_tail + PW'(FETCH_WIDTH);
                r_pc_q <= r_pc_q + 32'(4*FETCH_WIDTH);
            end
            r_head  <= r_head + PW'(w_pop_n);
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    // Present the oldest entries to decode; invalid slots read as zero.
    always_comb begin
        instr_o = {(32*FETCH_WIDTH){1'b0}};
        pc_o    = {(32*FETCH_WIDTH){1'b0}};
        valid_o = {FETCH_WIDTH{1'b0}};
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (CW'(k) < r_count) begin
                valid_o[k]         = 1'b1;
                instr_o[32*k +: 32] = r_mem_instr[r_head + PW'(k)];
                pc_o[32*k +: 32]    = r_mem_pc[r_head + PW'(k)];
            end else begin
                valid_o[k] = 1'b0;
            end
        end
    end

    assign imem_addr_o = r_pc_q;
    assign count_o     = r_count;

`ifdef FETCHQ_PERF_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_redir;

    // Saturating counters for full-queue stalls and redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full  <= 32'h0000_0000;
            r_perf_redir <= 32'h0000_0000;
        end else begin
            if (redirect_i && (r_perf_redir != 32'hFFFF_FFFF)) begin
                r_perf_redir <= r_perf_redir + 32'h0000_0001;
            end
            if (!redirect_i && !w_fetch_go && (r_perf_full != 32'hFFFF_FFFF)) begin
                r_perf_full <= r_perf_full + 32'h0000_0001;
            end
        end
    end

    assign perf_full_cycles_o = r_perf_full;
    assign perf_redirects_o   = r_perf_redir;
`endif

endmodule

// File: tb/tb_fetch_queue_nw.sv
module tb_fetch_queue_nw;

    localparam int FW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              redirect_i = 1'b0;
    logic [31:0]       redirect_pc_i = 32'h0;
    logic [31:0]       imem_addr_o;
    logic [32*FW-1:0]  imem_rdata_i;
    logic [1:0]        deq_count_i = 2'd0;
    logic [32*FW-1:0]  instr_o;
    logic [32*FW-1:0]  pc_o;
    logic [FW-1:0]     valid_o;
    logic [3:0]        count_o;
`ifdef FETCHQ_PERF_EN
    logic [31:0]       perf_full_cycles_o;
    logic [31:0]       perf_redirects_o;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_full;
    logic [31:0] m_redir;

    fetch_queue_nw #(.FETCH_WIDTH(2), .DEPTH(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i), .deq_count_i(deq_count_i),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .count_o(count_o)
`ifdef FETCHQ_PERF_EN
        , .perf_full_cycles_o(perf_full_cycles_o), .perf_redirects_o(perf_redirects_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: combinational read of FW consecutive words
    always_comb begin
        for (int k = 0; k < FW; k++) begin
            imem_rdata_i[32*k +: 32] = memf(imem_addr_o + 32'(4*k));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model, wait past posedge
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic [1:0] deq);
        int n;
        bit go;
        @(negedge clk);
        rst = r; redirect_i = rd; redirect_pc_i = rpc; deq_count_i = deq;
        if (r) begin
            m_q.delete(); m_pc = 32'h0; m_full = 32'h0; m_redir = 32'h0;
        end else if (rd) begin
            m_q.delete(); m_pc = {rpc[31:2], 2'b00}; m_redir = m_redir + 32'd1;
        end else begin
            go = (8 - m_q.size()) >= FW;
            n = (int'(deq) > m_q.size()) ? m_q.size() : int'(deq);
            repeat (n) void'(m_q.pop_front());
            if (go) begin
                for (int k = 0; k < FW; k++) m_q.push_back(m_pc + 32'(4*k));
                m_pc = m_pc + 32'(4*FW);
            end else begin
                m_full = m_full + 32'd1;
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Compare process: DUT outputs against the model after every edge
    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            check("count", 32'(count_o), 32'(m_q.size()));
            check("imem_addr", imem_addr_o, m_pc);
            for (int k = 0; k < FW; k++) begin
                check("valid", 32'(valid_o[k]), 32'(k < m_q.size()));
                if (k < m_q.size()) begin
                    check("pc_slot", pc_o[32*k +: 32], m_q[k]);
                    check("instr_slot", instr_o[32*k +: 32], memf(m_q[k]));
                end
            end
`ifdef FETCHQ_PERF_EN
            check("perf_full", perf_full_cycles_o, m_full);
            check("perf_redir", perf_redirects_o, m_redir);
`endif
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        // Reset state
        step(1'b1, 1'b0, 32'h0, 2'd0);
        check("rst_addr", imem_addr_o, 32'h0000_0000);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_pc0", pc_o[31:0], 32'h0);
        check("rst_instr1", instr_o[63:32], 32'h0);

        // Fill with no pops: addresses 0,8,0x10,0x18 then freeze at 0x20
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", imem_addr_o, 32'(8*i));
            step(1'b0, 1'b0, 32'h0, 2'd0);
        end
        check("full_count", 32'(count_o), 32'd8);
        check("full_addr", imem_addr_o, 32'h20);
        step(1'b0, 1'b0, 32'h0, 2'd0);
        check("stall_addr", imem_addr_o, 32'h20);

        // Pop 2 from full, then steady 2-in/2-out
        step(1'b0, 1'b0, 32'h0, 2'd2);
        check("pop_count", 32'(count_o), 32'd6);
        check("pop_addr", imem_addr_o, 32'h20);
        repeat (3) step(1'b0, 1'b0, 32'h0, 2'd2);
        check("steady_pc0", pc_o[31:0], 32'h20);
        check("steady_pc1", pc_o[63:32], 32'h24);
        check("steady_addr", imem_addr_o, 32'h38);

        // Reach count 5, then redirect with a pending pop
        step(1'b0, 1'b0, 32'h0, 2'd1);
        check("cnt7", 32'(count_o), 32'd7);
        step(1'b0, 1'b0, 32'h0, 2'd2);
        check("cnt5", 32'(count_o), 32'd5);
        step(1'b0, 1'b1, 32'h203, 2'd2);
        check("redir_count", 32'(count_o), 32'd0);
        check("redir_addr", imem_addr_o, 32'h200);
        // Pop request on an empty queue is clamped to zero
        step(1'b0, 1'b0, 32'h0, 2'd2);
        check("clamp_count", 32'(count_o), 32'd2);
        check("redir_pc0", pc_o[31:0], 32'h200);
        check("redir_pc1", pc_o[63:32], 32'h204);
        check("redir_valid", 32'(valid_o), 32'd3);

        // Back-to-back redirects: last wins; reset beats redirect
        step(1'b0, 1'b1, 32'h100, 2'd0);
        step(1'b0, 1'b1, 32'h302, 2'd0);
        check("b2b_addr", imem_addr_o, 32'h300);
        step(1'b0, 1'b0, 32'h0, 2'd0);
        step(1'b1, 1'b1, 32'h500, 2'd2);
        check("rst_over_redir", imem_addr_o, 32'h0);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 $urandom(), 2'($urandom_range(0, 2)));
            if (count_o > 4'd8) check("count_bound", 32'(count_o), 32'd8);
        end

        // Performance counter scenario: 3 redirects, 4 fills, 4 full stalls
        step(1'b1, 1'b0, 32'h0, 2'd0);
        repeat (3) step(1'b0, 1'b1, 32'h40, 2'd0);
        repeat (8) step(1'b0, 1'b0, 32'h0, 2'd0);
        check("perf_scn_count", 32'(count_o), 32'd8);
`ifdef FETCHQ_PERF_EN
        check("perf_redir_lit", perf_redirects_o, 32'd3);
        check("perf_full_lit", perf_full_cycles_o, 32'd4);
        step(1'b1, 1'b0, 32'h0, 2'd0);
        check("perf_redir_rst", perf_redirects_o, 32'd0);
        check("perf_full_rst", perf_full_cycles_o, 32'd0);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
